// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl
//
// Sits between the UART receiver and the CPU core. It accepts a framed program image one byte
// at a time and assembles 32-bit little-endian words. Each word is written to instruction
// memory, and the frame checksum is checked at the end. The core is held in reset until a clean
// load completes, then run_flag is raised.
//
// Frame: 0xA5, LEN_LO, LEN_HI, 4*N data bytes (LSB first per word), CHK.
// CHK is the XOR of the LEN bytes and every data byte.
//
// Parameters
//   ADDR_WIDTH     : instruction-memory word-address width (capacity 2^ADDR_WIDTH words)
//   TIMEOUT_CYCLES : max idle clocks between consecutive frame bytes once a frame has started
//
// Ports
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   rx_data    in   received byte
//   rx_valid   in   one-cycle strobe qualifying rx_data
//   imem_we    out  instruction-memory write enable (one-cycle pulse)
//   imem_addr  out  word address of the write
//   imem_wdata out  instruction word to write
//   cpu_rst    out  active-high hold on the core, high while not running
//   run_flag   out  program loaded and verified, core running
//   load_error out  sticky bad-frame indication, cleared by a new sync byte

module boot_loader_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_rst,
  output logic                  run_flag,
  output logic                  load_error
);

  localparam logic [7:0]  SyncByte = 8'hA5;
  // One extra bit so a full-capacity image (N = 2^ADDR_WIDTH) counts to N without wrapping.
  localparam int unsigned CntW     = ADDR_WIDTH + 1;
  localparam int unsigned TimerW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MaxWords = 17'(1) << ADDR_WIDTH;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StChk,
    StRun,
    StError
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [CntW-1:0]   word_cnt_q, word_cnt_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  // Holds the three lower bytes of the word being assembled. The 4th byte goes straight to
  // the write data.
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        chk_q, chk_d;
  logic [TimerW-1:0] timer_q, timer_d;

  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  run_q, run_d;
  logic                  err_q, err_d;

  logic        in_frame;
  logic        timeout;
  logic        is_sync;
  logic [15:0] len_full;
  logic [16:0] next_word;

  // The inter-byte timer only runs while a frame is in progress.
  assign in_frame  = (state_q == StLenLo) || (state_q == StLenHi) ||
                     (state_q == StData)  || (state_q == StChk);
  assign timeout   = in_frame && (timer_q == TimerLast);
  assign is_sync   = rx_valid && (rx_data == SyncByte);
  assign len_full  = {rx_data, len_q[7:0]};
  assign next_word = 17'(word_cnt_q) + 17'd1;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    chk_d      = chk_q;
    timer_d    = '0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cpu_rst_d  = cpu_rst_q;
    run_d      = run_q;
    err_d      = err_q;

    if (in_frame && !rx_valid) begin
      timer_d = timer_q + TimerW'(1);
    end

    if (timeout) begin
      // A byte arriving on the same edge is dropped; the timeout takes priority.
      state_d = StError;
      err_d   = 1'b1;
      timer_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (is_sync) begin
            chk_d      = '0;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            state_d    = StLenLo;
          end
        end

        StLenLo: begin
          if (rx_valid) begin
            len_d[7:0] = rx_data;
            chk_d      = chk_q ^ rx_data;
            state_d    = StLenHi;
          end
        end

        StLenHi: begin
          if (rx_valid) begin
            len_d[15:8] = rx_data;
            chk_d       = chk_q ^ rx_data;
            if ({1'b0, len_full} > MaxWords) begin
              state_d = StError;
              err_d   = 1'b1;
            end else if (len_full == 16'd0) begin
              state_d = StChk;
            end else begin
              state_d = StData;
            end
          end
        end

        StData: begin
          if (rx_valid) begin
            chk_d      = chk_q ^ rx_data;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              we_d       = 1'b1;
              addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
              wdata_d    = {rx_data, asm_q};
              word_cnt_d = word_cnt_q + CntW'(1);
              if (next_word == {1'b0, len_q}) begin
                state_d = StChk;
              end
            end else begin
              asm_d = {rx_data, asm_q[23:8]};
            end
          end
        end

        StChk: begin
          if (rx_valid) begin
            if (rx_data == chk_q) begin
              state_d   = StRun;
              run_d     = 1'b1;
              cpu_rst_d = 1'b0;
            end else begin
              state_d = StError;
              err_d   = 1'b1;
            end
          end
        end

        // Only reset leaves RUN.
        StRun: begin
          state_d = StRun;
        end

        StError: begin
          if (is_sync) begin
            err_d      = 1'b0;
            chk_d      = '0;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            state_d    = StLenLo;
          end
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      chk_q      <= '0;
      timer_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b1;
      run_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      chk_q      <= chk_d;
      timer_q    <= timer_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      run_q      <= run_d;
      err_q      <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign run_flag   = run_q;
  assign load_error = err_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed testbench for boot_loader_ctrl (ADDR_WIDTH=2, TIMEOUT_CYCLES=50).
// Inputs are driven 1 time unit after the rising edge. Outputs are checked at the same point,
// after the edge that produced them. A negedge monitor logs every imem_we pulse.

module tb_boot_loader_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       imem_we;
  logic [1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic       cpu_rst;
  logic       run_flag;
  logic       load_error;

  int checks   = 0;
  int failures = 0;

  logic [1:0]  log_addr[$];
  logic [31:0] log_data[$];

  // N=2 body: LEN 02 00, words 0x00000013 and 0x00100093.
  // XOR of LEN and data bytes: 02^13^93^10 = 0x92.
  logic [7:0] good_body [0:9] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                  8'h93, 8'h00, 8'h10, 8'h00};
  logic [7:0] good_chk = 8'h92;

  boot_loader_ctrl #(
    .ADDR_WIDTH    (2),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_rst   (cpu_rst),
    .run_flag  (run_flag),
    .load_error(load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      log_addr.push_back(imem_addr);
      log_data.push_back(imem_wdata);
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic send_good_body();
    for (int i = 0; i < 10; i++) send(good_body[i]);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (imem_we !== 1'b0) begin
      failures++; $display("FAIL reset_we: got %b want 0", imem_we);
    end
    checks++;
    if (imem_addr !== 2'd0 || imem_wdata !== 32'd0) begin
      failures++; $display("FAIL reset_addr_data: got %h/%h want 0/0", imem_addr, imem_wdata);
    end
    checks++;
    if (cpu_rst !== 1'b1 || run_flag !== 1'b0 || load_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got rst=%b run=%b err=%b want 1/0/0", cpu_rst, run_flag,
               load_error);
    end
  endtask

  task automatic test_good_load();
    do_reset();
    send(8'hA5);
    for (int i = 0; i < 6; i++) send(good_body[i]);
    // 4th data byte of word 0 was just sampled: pulse must be visible now.
    checks++;
    if (imem_we !== 1'b1 || imem_addr !== 2'd0 || imem_wdata !== 32'h0000_0013) begin
      failures++;
      $display("FAIL good_first_write: got we=%b addr=%h data=%h want 1/0/00000013", imem_we,
               imem_addr, imem_wdata);
    end
    for (int i = 6; i < 10; i++) send(good_body[i]);
    checks++;
    if (run_flag !== 1'b0 || cpu_rst !== 1'b1) begin
      failures++; $display("FAIL good_pre_chk: got run=%b rst=%b want 0/1", run_flag, cpu_rst);
    end
    send(good_chk);
    checks++;
    if (run_flag !== 1'b1 || cpu_rst !== 1'b0 || load_error !== 1'b0) begin
      failures++;
      $display("FAIL good_run: got run=%b rst=%b err=%b want 1/0/0", run_flag, cpu_rst,
               load_error);
    end
    checks++;
    if (log_addr.size() !== 2) begin
      failures++; $display("FAIL good_write_count: got %0d want 2", log_addr.size());
    end else begin
      checks++;
      if (log_addr[0] !== 2'd0 || log_data[0] !== 32'h0000_0013) begin
        failures++;
        $display("FAIL good_word0: got %h/%h want 0/00000013", log_addr[0], log_data[0]);
      end
      checks++;
      if (log_addr[1] !== 2'd1 || log_data[1] !== 32'h0010_0093) begin
        failures++;
        $display("FAIL good_word1: got %h/%h want 1/00100093", log_addr[1], log_data[1]);
      end
    end
  endtask

  // Continues from a running core: later bytes must change nothing.
  task automatic test_run_ignores();
    send(8'hA5);
    send(8'h01);
    send(8'h00);
    send(8'h13);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    checks++;
    if (run_flag !== 1'b1 || load_error !== 1'b0 || log_addr.size() !== 2) begin
      failures++;
      $display("FAIL run_ignores: got run=%b err=%b writes=%0d want 1/0/2", run_flag, load_error,
               log_addr.size());
    end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    send(8'hA5);
    send_good_body();
    send(8'h83);
    checks++;
    if (load_error !== 1'b1 || run_flag !== 1'b0 || cpu_rst !== 1'b1) begin
      failures++;
      $display("FAIL bad_chk: got err=%b run=%b rst=%b want 1/0/1", load_error, run_flag,
               cpu_rst);
    end
    checks++;
    if (log_addr.size() !== 2) begin
      failures++; $display("FAIL bad_chk_writes: got %0d want 2", log_addr.size());
    end
    send(8'h55);
    send(8'hA5);
    checks++;
    if (load_error !== 1'b0) begin
      failures++; $display("FAIL bad_chk_clear: got %b want 0", load_error);
    end
    send_good_body();
    send(good_chk);
    checks++;
    if (run_flag !== 1'b1 || cpu_rst !== 1'b0 || load_error !== 1'b0) begin
      failures++;
      $display("FAIL bad_chk_recover: got run=%b rst=%b err=%b want 1/0/0", run_flag, cpu_rst,
               load_error);
    end
  endtask

  task automatic test_oversize();
    do_reset();
    send(8'hA5);
    send(8'h05);
    checks++;
    if (load_error !== 1'b0) begin
      failures++; $display("FAIL oversize_early: got %b want 0", load_error);
    end
    send(8'h00);
    checks++;
    if (load_error !== 1'b1 || cpu_rst !== 1'b1) begin
      failures++;
      $display("FAIL oversize_err: got err=%b rst=%b want 1/1", load_error, cpu_rst);
    end
    for (int i = 0; i < 8; i++) send(8'h13);
    checks++;
    if (log_addr.size() !== 0 || load_error !== 1'b1) begin
      failures++;
      $display("FAIL oversize_writes: got writes=%0d err=%b want 0/1", log_addr.size(),
               load_error);
    end
  endtask

  // Full capacity: N=4 with bytes 01..10. CHK = 04 ^ (01^..^10) = 04 ^ 10 = 0x14.
  task automatic test_max_len();
    logic [31:0] exp_word;
    do_reset();
    send(8'hA5);
    send(8'h04);
    send(8'h00);
    for (int i = 1; i <= 16; i++) send(8'(i));
    send(8'h14);
    checks++;
    if (run_flag !== 1'b1 || load_error !== 1'b0) begin
      failures++;
      $display("FAIL max_run: got run=%b err=%b want 1/0", run_flag, load_error);
    end
    checks++;
    if (log_addr.size() !== 4) begin
      failures++; $display("FAIL max_write_count: got %0d want 4", log_addr.size());
    end else begin
      for (int w = 0; w < 4; w++) begin
        exp_word = {8'(4*w + 4), 8'(4*w + 3), 8'(4*w + 2), 8'(4*w + 1)};
        checks++;
        if (log_addr[w] !== 2'(w) || log_data[w] !== exp_word) begin
          failures++;
          $display("FAIL max_word%0d: got %h/%h want %h/%h", w, log_addr[w], log_data[w],
                   2'(w), exp_word);
        end
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send(8'hA5);
    send(8'h01);
    send(8'h00);
    send(8'h13);
    repeat (49) @(posedge clk);
    #1;
    checks++;
    if (load_error !== 1'b0) begin
      failures++; $display("FAIL timeout_early: got %b want 0 after 49 idle cycles", load_error);
    end
    @(posedge clk);
    #1;
    checks++;
    if (load_error !== 1'b1 || cpu_rst !== 1'b1 || run_flag !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err: got err=%b rst=%b run=%b want 1/1/0", load_error, cpu_rst,
               run_flag);
    end
    checks++;
    if (log_addr.size() !== 0) begin
      failures++; $display("FAIL timeout_writes: got %0d want 0", log_addr.size());
    end
  endtask

  task automatic test_noise_zero_len();
    do_reset();
    send(8'h00);
    send(8'hFF);
    send(8'h5A);
    checks++;
    if (load_error !== 1'b0 || run_flag !== 1'b0) begin
      failures++;
      $display("FAIL noise: got err=%b run=%b want 0/0", load_error, run_flag);
    end
    send(8'hA5);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    checks++;
    if (run_flag !== 1'b1 || cpu_rst !== 1'b0 || log_addr.size() !== 0) begin
      failures++;
      $display("FAIL zero_len: got run=%b rst=%b writes=%0d want 1/0/0", run_flag, cpu_rst,
               log_addr.size());
    end
  endtask

  task automatic test_reset_mid_data();
    do_reset();
    send(8'hA5);
    send(8'h02);
    send(8'h00);
    send(8'h77);
    send(8'h66);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (imem_we !== 1'b0 || imem_addr !== 2'd0 || imem_wdata !== 32'd0 || cpu_rst !== 1'b1 ||
        run_flag !== 1'b0 || load_error !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got we=%b addr=%h data=%h rst=%b run=%b err=%b",
               imem_we, imem_addr, imem_wdata, cpu_rst, run_flag, load_error);
    end
    log_addr.delete();
    log_data.delete();
    send(8'hA5);
    send_good_body();
    send(good_chk);
    checks++;
    if (run_flag !== 1'b1 || log_addr.size() !== 2) begin
      failures++;
      $display("FAIL mid_reset_reload: got run=%b writes=%0d want 1/2", run_flag,
               log_addr.size());
    end else begin
      checks++;
      if (log_addr[0] !== 2'd0 || log_data[0] !== 32'h0000_0013) begin
        failures++;
        $display("FAIL mid_reset_word0: got %h/%h want 0/00000013", log_addr[0], log_data[0]);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(posedge clk);
    #1;
    test_reset();
    test_good_load();
    test_run_ignores();
    test_bad_checksum();
    test_oversize();
    test_max_len();
    test_timeout();
    test_noise_zero_len();
    test_reset_mid_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
